write_arbiter: RTL and testbench

WRITE_ARBITER -- requirements
Module: write_arbiter

---
 rtl/write_arbiter_pkg.sv | 42 ++++
 rtl/write_arbiter_if.sv | 43 ++++
 rtl/write_arbiter_addr_decoder.sv | 30 +++
 rtl/write_arbiter.sv | 122 ++++++++++++
 tb/tb_write_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/write_arbiter_pkg.sv
// Shared AXI write-path types: FSM states, slave indices and the address map.
package write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    localparam int SEL_W   = 7;
    localparam int SLV_ROM  = 0;
    localparam int SLV_IM   = 1;
    localparam int SLV_DM   = 2;
    localparam int SLV_DMA  = 3;
    localparam int SLV_WDT  = 4;
    localparam int SLV_DRAM = 5;
    localparam int SLV_DEF  = 6;

    localparam logic [1:0] GNT_M1 = 2'b01;
    localparam logic [1:0] GNT_M2 = 2'b10;

    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_LIMIT  = 32'h0000_1FFF;
    localparam logic [31:0] IM_BASE    = 32'h0001_0000;
    localparam logic [31:0] IM_LIMIT   = 32'h0001_FFFF;
    localparam logic [31:0] DM_BASE    = 32'h0002_0000;
    localparam logic [31:0] DM_LIMIT   = 32'h0002_FFFF;
    localparam logic [31:0] DMA_BASE   = 32'h1002_0000;
    localparam logic [31:0] DMA_LIMIT  = 32'h1002_03FF;
    localparam logic [31:0] WDT_BASE   = 32'h1001_0000;
    localparam logic [31:0] WDT_LIMIT  = 32'h1001_03FF;
    localparam logic [31:0] DRAM_BASE  = 32'h2000_0000;
    localparam logic [31:0] DRAM_LIMIT = 32'h201F_FFFF;

    function automatic logic in_window(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (a >= base) && (a <= limit);
    endfunction

endpackage

// File: rtl/write_arbiter_if.sv
// Write-channel arbitration bundle: master requests, slave handshakes and the
// steering controls the arbiter produces.
interface write_arbiter_if
    import write_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
);
    logic              AWVALID_M1;
    logic [ADDR_W-1:0] AWADDR_M1;
    logic [LEN_W-1:0]  AWLEN_M1;
    logic              AWVALID_M2;
    logic [ADDR_W-1:0] AWADDR_M2;
    logic [LEN_W-1:0]  AWLEN_M2;
    logic [5:0]        AWREADY_S;
    logic              WVALID_G;
    logic              WLAST_G;
    logic              WREADY_G;
    logic              BVALID_G;
    logic              BREADY_G;
    logic [1:0]        grant;
    logic [SEL_W-1:0]  slave_sel;
    logic              aw_en;
    logic              w_en;
    logic              b_en;
    logic              len_err;

    // Arbiter side.
    modport slave (
        input  AWVALID_M1, AWADDR_M1, AWLEN_M1,
        input  AWVALID_M2, AWADDR_M2, AWLEN_M2,
        input  AWREADY_S, WVALID_G, WLAST_G, WREADY_G, BVALID_G, BREADY_G,
        output grant, slave_sel, aw_en, w_en, b_en, len_err
    );

    // Bus/environment side.
    modport master (
        output AWVALID_M1, AWADDR_M1, AWLEN_M1,
        output AWVALID_M2, AWADDR_M2, AWLEN_M2,
        output AWREADY_S, WVALID_G, WLAST_G, WREADY_G, BVALID_G, BREADY_G,
        input  grant, slave_sel, aw_en, w_en, b_en, len_err
    );
endinterface

// File: rtl/write_arbiter_addr_decoder.sv
// Combinational address decoder: address to one-hot slave select, bit 6 is the
// DECERR default slave. Shared with the read path.
module addr_decoder
    import write_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  sel
);
    logic [63:0] a64;
    logic [31:0] a32;
    logic        hi_zero;

    always_comb begin
        a64     = 64'(addr);
        a32     = a64[31:0];
        hi_zero = (a64[63:32] == 32'h0);
        sel     = '0;
        // Any bit above the 32-bit map makes the access unmapped.
        if (!hi_zero)                                 sel[SLV_DEF]  = 1'b1;
        else if (in_window(a32, ROM_BASE, ROM_LIMIT))   sel[SLV_ROM]  = 1'b1;
        else if (in_window(a32, IM_BASE, IM_LIMIT))     sel[SLV_IM]   = 1'b1;
        else if (in_window(a32, DM_BASE, DM_LIMIT))     sel[SLV_DM]   = 1'b1;
        else if (in_window(a32, DMA_BASE, DMA_LIMIT))   sel[SLV_DMA]  = 1'b1;
        else if (in_window(a32, WDT_BASE, WDT_LIMIT))   sel[SLV_WDT]  = 1'b1;
        else if (in_window(a32, DRAM_BASE, DRAM_LIMIT)) sel[SLV_DRAM] = 1'b1;
        else                                           sel[SLV_DEF]  = 1'b1;
    end
endmodule

// File: rtl/write_arbiter.sv
// Two-master AXI write arbiter: round-robin grant, address decode and a
// burst-tracking FSM that steers AW, W and B between the granted master and slave.
module write_arbiter
    import write_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input logic            clk,
    input logic            rst,
    write_arbiter_if.slave bus
);
    logic [1:0]        rst_sync_q;
    logic              rst_n_int;

    wr_state_e         state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_m2_q, last_m2_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              len_err_q, len_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [1:0]        pick;
    logic [SEL_W-1:0]  dec_sel;
    logic              aw_ready;
    logic              beat;

    // Assert asynchronously, deassert two edges later so the FSM leaves reset cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    addr_decoder #(.ADDR_W(ADDR_W)) u_addr_decoder (
        .addr (addr_q),
        .sel  (dec_sel)
    );

    assign aw_ready = dec_sel[SLV_DEF] | (|(dec_sel[5:0] & bus.AWREADY_S));
    assign beat     = bus.WVALID_G & bus.WREADY_G;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_m2_q <= 1'b1;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_m2_q <= last_m2_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    // Captured request; qualified by state, so no reset is needed.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        len_q  <= len_d;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_m2_d = last_m2_q;
        cnt_d     = cnt_q;
        len_err_d = 1'b0;
        addr_d    = addr_q;
        len_d     = len_q;
        pick      = '0;

        if (bus.AWVALID_M1 && bus.AWVALID_M2) pick = last_m2_q ? GNT_M1 : GNT_M2;
        else if (bus.AWVALID_M1)              pick = GNT_M1;
        else if (bus.AWVALID_M2)              pick = GNT_M2;

        unique case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    state_d = ST_ADDR;
                    grant_d = pick;
                    addr_d  = pick[1] ? bus.AWADDR_M2 : bus.AWADDR_M1;
                    len_d   = pick[1] ? bus.AWLEN_M2  : bus.AWLEN_M1;
                end
            end
            ST_ADDR: begin
                if (aw_ready) begin
                    state_d = ST_DATA;
                    cnt_d   = len_q;
                end
            end
            ST_DATA: begin
                // Termination follows the counter; WLAST only feeds the error flag.
                if (beat) begin
                    len_err_d = bus.WLAST_G != (cnt_q == '0);
                    if (cnt_q == '0) state_d = ST_RESP;
                    else             cnt_d   = cnt_q - LEN_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.BVALID_G && bus.BREADY_G) begin
                    state_d   = ST_IDLE;
                    last_m2_d = grant_q[1];
                    grant_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.aw_en     = (state_q == ST_ADDR);
        bus.w_en      = (state_q == ST_DATA);
        bus.b_en      = (state_q == ST_RESP);
        bus.grant     = grant_q;
        bus.slave_sel = (state_q != ST_IDLE) ? dec_sel : '0;
        bus.len_err   = len_err_q;
    end
endmodule

// File: tb/tb_write_arbiter.sv
// Self-checking bench for write_arbiter: table-driven bursts plus hand sequences
// for length errors and mid-burst reset.
module tb_write_arbiter;
    import write_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    write_arbiter_if #(.ADDR_W(32), .LEN_W(4)) bus ();
    write_arbiter #(.ADDR_W(32), .LEN_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [3:0]  len;
        int          dly;
        logic [1:0]  eg;
        logic [6:0]  es;
    } vec_t;

    typedef struct packed {
        logic [1:0] g;
        logic [6:0] s;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_grant"}, 32'(bus.grant), 32'(0));
        check({name, "_sel"},   32'(bus.slave_sel), 32'(0));
        check({name, "_en"},    32'({bus.aw_en, bus.w_en, bus.b_en}), 32'(0));
        check({name, "_lerr"},  32'(bus.len_err), 32'(0));
    endtask

    task automatic issue(input logic [1:0] req, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [3:0] len, input logic [1:0] eg, input logic [6:0] es);
        exp_t e;
        bus.AWVALID_M1 = req[0];
        bus.AWVALID_M2 = req[1];
        bus.AWADDR_M1  = a1;
        bus.AWADDR_M2  = a2;
        // The losing master carries a different length so a wrong capture shows up in the beat count.
        bus.AWLEN_M1   = (eg == 2'b01) ? len : 4'(len + 4'd5);
        bus.AWLEN_M2   = (eg == 2'b10) ? len : 4'(len + 4'd5);
        e.g = eg;
        e.s = es;
        sb_q.push_back(e);
        step();
        bus.AWVALID_M1 = 1'b0;
        bus.AWVALID_M2 = 1'b0;
        check("addr_aw_en", 32'(bus.aw_en), 32'(1));
        check("addr_wb_en", 32'({bus.w_en, bus.b_en}), 32'(0));
        if (bus.aw_en && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("grant", 32'(bus.grant), 32'(e.g));
            check("slave_sel", 32'(bus.slave_sel), 32'(e.s));
        end else if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
    endtask

    task automatic addr_ready(input logic [1:0] eg, input logic [6:0] es, input int dly);
        // Requests while busy must be ignored.
        bus.AWVALID_M1 = 1'b1;
        bus.AWVALID_M2 = 1'b1;
        if (!es[6]) begin
            for (int i = 0; i < dly; i++) begin
                bus.AWREADY_S = ~es[5:0];
                step();
                check("addr_wait", 32'(bus.aw_en), 32'(1));
            end
            bus.AWREADY_S = es[5:0];
        end else begin
            bus.AWREADY_S = 6'b0;
        end
        step();
        bus.AWREADY_S = 6'b0;
        check("data_entry_w_en", 32'({bus.aw_en, bus.w_en}), 32'(1));
        check("data_grant_stable", 32'(bus.grant), 32'(eg));
        check("data_sel_stable", 32'(bus.slave_sel), 32'(es));
    endtask

    task automatic beat(input logic wlast, input logic stall, input logic exp_err, input logic exp_last);
        if (stall) begin
            bus.WVALID_G = 1'b1;
            bus.WREADY_G = 1'b0;
            bus.WLAST_G  = wlast;
            step();
            check("stall_hold", 32'(bus.w_en), 32'(1));
            check("stall_lerr", 32'(bus.len_err), 32'(0));
        end
        bus.WVALID_G = 1'b1;
        bus.WREADY_G = 1'b1;
        bus.WLAST_G  = wlast;
        step();
        bus.WVALID_G = 1'b0;
        bus.WREADY_G = 1'b0;
        bus.WLAST_G  = 1'b0;
        check("beat_len_err", 32'(bus.len_err), 32'(exp_err));
        check("beat_w_en", 32'(bus.w_en), 32'(!exp_last));
        check("beat_b_en", 32'(bus.b_en), 32'(exp_last));
    endtask

    task automatic bresp(input logic [1:0] eg, input logic [6:0] es);
        bus.AWVALID_M1 = 1'b0;
        bus.AWVALID_M2 = 1'b0;
        bus.BVALID_G   = 1'b1;
        bus.BREADY_G   = 1'b0;
        step();
        check("resp_hold", 32'(bus.b_en), 32'(1));
        check("resp_grant", 32'(bus.grant), 32'(eg));
        check("resp_sel", 32'(bus.slave_sel), 32'(es));
        check("len_err_width", 32'(bus.len_err), 32'(0));
        bus.BREADY_G = 1'b1;
        step();
        bus.BVALID_G = 1'b0;
        bus.BREADY_G = 1'b0;
        check_all_zero("idle_after_b");
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.req, v.a1, v.a2, v.len, v.eg, v.es);
        addr_ready(v.eg, v.es, v.dly);
        for (int i = 0; i <= int'(v.len); i++)
            beat(i == int'(v.len), i == 1, 1'b0, i == int'(v.len));
        bresp(v.eg, v.es);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        // req, addr M1, addr M2, len, AWREADY delay, grant, slave_sel
        vecs.push_back('{2'b11, 32'h0000_0100, 32'h1001_0010, 4'd1,  1, 2'b01, 7'b0000001});
        vecs.push_back('{2'b11, 32'h0002_0000, 32'h1002_0000, 4'd2,  0, 2'b10, 7'b0001000});
        vecs.push_back('{2'b01, 32'h0002_0010, 32'h0,         4'd3,  2, 2'b01, 7'b0000100});
        vecs.push_back('{2'b10, 32'h0,         32'h3000_0000, 4'd0,  0, 2'b10, 7'b1000000});
        vecs.push_back('{2'b01, 32'h0000_1FFF, 32'h0,         4'd0,  1, 2'b01, 7'b0000001});
        vecs.push_back('{2'b10, 32'h0,         32'h0000_2000, 4'd1,  0, 2'b10, 7'b1000000});
        vecs.push_back('{2'b01, 32'h0001_0000, 32'h0,         4'd2,  1, 2'b01, 7'b0000010});
        vecs.push_back('{2'b10, 32'h0,         32'h0001_FFFF, 4'd0,  0, 2'b10, 7'b0000010});
        vecs.push_back('{2'b01, 32'h0002_FFFF, 32'h0,         4'd1,  0, 2'b01, 7'b0000100});
        vecs.push_back('{2'b10, 32'h0,         32'h1002_03FF, 4'd0,  1, 2'b10, 7'b0001000});
        vecs.push_back('{2'b01, 32'h1002_0400, 32'h0,         4'd0,  0, 2'b01, 7'b1000000});
        vecs.push_back('{2'b10, 32'h0,         32'h1001_0000, 4'd1,  0, 2'b10, 7'b0010000});
        vecs.push_back('{2'b01, 32'h1001_03FF, 32'h0,         4'd0,  1, 2'b01, 7'b0010000});
        vecs.push_back('{2'b10, 32'h0,         32'h2000_0000, 4'd15, 0, 2'b10, 7'b0100000});
        vecs.push_back('{2'b01, 32'h201F_FFFF, 32'h0,         4'd0,  1, 2'b01, 7'b0100000});
        vecs.push_back('{2'b10, 32'h0,         32'h2020_0000, 4'd0,  0, 2'b10, 7'b1000000});
        vecs.push_back('{2'b01, 32'h0000_FFFF, 32'h0,         4'd0,  0, 2'b01, 7'b1000000});

        bus.AWVALID_M1 = 1'b0; bus.AWADDR_M1 = '0; bus.AWLEN_M1 = '0;
        bus.AWVALID_M2 = 1'b0; bus.AWADDR_M2 = '0; bus.AWLEN_M2 = '0;
        bus.AWREADY_S  = '0;
        bus.WVALID_G   = 1'b0; bus.WLAST_G  = 1'b0; bus.WREADY_G = 1'b0;
        bus.BVALID_G   = 1'b0; bus.BREADY_G = 1'b0;

        step();
        step();
        check_all_zero("reset_state");
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_release_grant", 32'(bus.grant), 32'(0));
        end

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Length mismatch: WLAST early on beat 2, missing on beat 3.
        issue(2'b01, 32'h0000_0100, 32'h0, 4'd2, 2'b01, 7'b0000001);
        addr_ready(2'b01, 7'b0000001, 0);
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 1'b0);
        beat(1'b0, 1'b0, 1'b1, 1'b1);
        bresp(2'b01, 7'b0000001);

        // Reset mid-burst after one of four beats.
        issue(2'b01, 32'h2000_0000, 32'h0, 4'd3, 2'b01, 7'b0100000);
        addr_ready(2'b01, 7'b0100000, 1);
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check_all_zero("mid_burst_reset");
        step();
        step();
        check_all_zero("reset_hold");
        bus.AWVALID_M1 = 1'b0;
        bus.AWVALID_M2 = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_spurious_grant", 32'({bus.grant, bus.aw_en}), 32'(0));
        end
        issue(2'b10, 32'h0, 32'h0001_0000, 4'd1, 2'b10, 7'b0000010);
        addr_ready(2'b10, 7'b0000010, 0);
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b1);
        bresp(2'b10, 7'b0000010);

        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
